softex_acc_row_seq: RTL

- Sequences the softex accumulator, which is instantiated alongside this block as a separate module, through a multi-row softmax-denominator job.
- For each row it streams score exponentials in as addends and forwards max-update correction factors as multiplicands.
- Once the row length is reached it triggers the reciprocal (Newton) phase, captures the result, and hands it downstream.
- Sits between the softex stream front-end and the accumulator; owns all accumulator clear/invert sequencing.

---
 rtl/softex_pkg.sv | 20 ++
 rtl/softex_acc_seq_cnt.sv | 43 ++++
 rtl/softex_acc_row_seq.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/softex_pkg.sv
// Shared types for the softex accumulator row sequencer: FSM states,
// per-job configuration and the default length-field width.
package softex_pkg;

    localparam int unsigned DEFAULT_LEN_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        DRAIN,
        WAIT_RES,
        OUT
    } acc_seq_state_e;

    typedef struct packed {
        logic [DEFAULT_LEN_WIDTH-1:0] row_len;
        logic [DEFAULT_LEN_WIDTH-1:0] n_rows;
    } acc_seq_cfg_t;

endpackage

// File: rtl/softex_acc_seq_cnt.sv
// Loadable, clearable up-counter with an equality terminal-count flag.
// Used for both the element-in-row and row-in-job counts.
module softex_acc_seq_cnt #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             inc_i,
    input  logic [WIDTH-1:0] term_val_i,
    output logic             term_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Equality compare only: the count never needs to pass the terminal value.
    assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/softex_acc_row_seq.sv
// Row sequencer for the softex accumulator: streams addends and correction
// factors per row, triggers the reciprocal phase and forwards each result.
module softex_acc_row_seq
    import softex_pkg::*;
#(
    parameter int unsigned ADD_WIDTH = 32,
    parameter int unsigned MUL_WIDTH = 16,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned LEN_WIDTH = DEFAULT_LEN_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 start_i,
    input  logic [LEN_WIDTH-1:0] row_len_i,
    input  logic [LEN_WIDTH-1:0] n_rows_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [ADD_WIDTH-1:0] in_data_i,
    input  logic                 fact_valid_i,
    output logic                 fact_ready_o,
    input  logic [MUL_WIDTH-1:0] fact_i,
    output logic                 acc_add_valid_o,
    output logic [ADD_WIDTH-1:0] acc_add_o,
    output logic                 acc_mul_valid_o,
    output logic [MUL_WIDTH-1:0] acc_mul_o,
    input  logic                 acc_ready_i,
    output logic                 acc_clear_o,
    output logic                 acc_inv_o,
    input  logic                 acc_valid_i,
    input  logic [ACC_WIDTH-1:0] acc_acc_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [ACC_WIDTH-1:0] out_data_o
);

    acc_seq_state_e        state_q, state_d;
    acc_seq_cfg_t          cfg_q, cfg_d;
    logic [ACC_WIDTH-1:0]  result_q, result_d;
    logic                  clear_pulse_q, clear_pulse_d;
    logic                  inv_q, inv_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  cnt_rst;
    logic                  elem_load;
    logic                  elem_inc;
    logic                  elem_last;
    logic                  row_load;
    logic                  row_inc;
    logic                  row_last;

    softex_acc_seq_cnt #(
        .WIDTH (LEN_WIDTH)
    ) u_elem_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (cnt_rst),
        .load_i     (elem_load),
        .load_val_i ('0),
        .inc_i      (elem_inc),
        .term_val_i (cfg_q.row_len - LEN_WIDTH'(1)),
        .term_o     (elem_last)
    );

    softex_acc_seq_cnt #(
        .WIDTH (LEN_WIDTH)
    ) u_row_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (cnt_rst),
        .load_i     (row_load),
        .load_val_i ('0),
        .inc_i      (row_inc),
        .term_val_i (cfg_q.n_rows - LEN_WIDTH'(1)),
        .term_o     (row_last)
    );

    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d         = state_q;
        cfg_d           = cfg_q;
        result_d        = result_q;
        clear_pulse_d   = 1'b0;
        inv_d           = 1'b0;
        done_d          = 1'b0;
        err_d           = 1'b0;
        cnt_rst         = 1'b0;
        elem_load       = 1'b0;
        row_load        = 1'b0;
        row_inc         = 1'b0;
        in_ready_o      = 1'b0;
        fact_ready_o    = 1'b0;
        acc_add_valid_o = 1'b0;
        acc_mul_valid_o = 1'b0;

        if (clear_i) begin
            state_d       = IDLE;
            result_d      = '0;
            clear_pulse_d = 1'b1;
            cnt_rst       = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        if (row_len_i == '0 || n_rows_i == '0) begin
                            err_d = 1'b1;
                        end else begin
                            cfg_d.row_len = row_len_i;
                            cfg_d.n_rows  = n_rows_i;
                            clear_pulse_d = 1'b1;
                            elem_load     = 1'b1;
                            row_load      = 1'b1;
                            state_d       = ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    // Operands are held back during the clear cycle so they
                    // cannot collide with the accumulator reset.
                    if (!clear_pulse_q) begin
                        in_ready_o      = acc_ready_i;
                        fact_ready_o    = acc_ready_i;
                        acc_add_valid_o = in_valid_i;
                        acc_mul_valid_o = fact_valid_i;
                        if (in_valid_i && acc_ready_i && elem_last) begin
                            state_d = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (acc_ready_i) begin
                        inv_d   = 1'b1;
                        state_d = WAIT_RES;
                    end
                end
                WAIT_RES: begin
                    if (acc_valid_i) begin
                        result_d = acc_acc_i;
                        state_d  = OUT;
                    end
                end
                OUT: begin
                    if (out_ready_i) begin
                        if (row_last) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            row_inc       = 1'b1;
                            elem_load     = 1'b1;
                            clear_pulse_d = 1'b1;
                            state_d       = ACCUM;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign elem_inc = in_valid_i & in_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            cfg_q         <= '0;
            result_q      <= '0;
            clear_pulse_q <= 1'b0;
            inv_q         <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            cfg_q         <= cfg_d;
            result_q      <= result_d;
            clear_pulse_q <= clear_pulse_d;
            inv_q         <= inv_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign acc_clear_o = clear_pulse_q;
    assign acc_inv_o   = inv_q;
    assign acc_add_o   = in_data_i;
    assign acc_mul_o   = fact_i;
    assign out_valid_o = (state_q == OUT);
    assign out_data_o  = result_q;

endmodule
